// File: rtl/clint_pkg.sv
// clint_pkg: shared constants for the core-local interruptor.
//   XLEN            - data bus width
//   MTIME_W         - width of mtime / mtimecmp
//   OFF_*           - register offsets decoded from addr_i[15:0]
//   MTIMECMP_RST    - reset value of mtimecmp (all ones, timer interrupt held off)
//   reg_sel_e       - decoded register select
//   decode_off()    - maps a 16-bit offset onto reg_sel_e
package clint_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned MTIME_W = 64;

    localparam logic [15:0] OFF_MSIP        = 16'h0000;
    localparam logic [15:0] OFF_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] OFF_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] OFF_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] OFF_MTIME_HI    = 16'hBFFC;

    localparam logic [MTIME_W-1:0] MTIMECMP_RST = '1;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_MTIME_LO,
        REG_MTIME_HI
    } reg_sel_e;

    function automatic reg_sel_e decode_off(input logic [15:0] off);
        reg_sel_e sel;
        case (off)
            OFF_MSIP:        sel = REG_MSIP;
            OFF_MTIMECMP_LO: sel = REG_CMP_LO;
            OFF_MTIMECMP_HI: sel = REG_CMP_HI;
            OFF_MTIME_LO:    sel = REG_MTIME_LO;
            OFF_MTIME_HI:    sel = REG_MTIME_HI;
            default:         sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/clint_tick_div.sv
// clint_tick_div: divides clk_i down to a one-cycle tick for mtime.
//   clk_i  - clock
//   rst_i  - synchronous active-low reset
//   tick_o - high for one cycle whenever the counter sits at TICK_DIV-1
// TICK_DIV = 1 holds the counter at 0, so tick_o is high every cycle.
module clint_tick_div #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

    logic [15:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clint.sv
// clint: machine timer (mtime/mtimecmp) and software interrupt (msip).
//   clk_i          - clock
//   rst_i          - synchronous active-low reset
//   req_i, we_i    - access strobe and write enable (already address-qualified)
//   addr_i         - byte address, only [15:0] decoded
//   wdata_i        - full-word write data
//   rdata_o        - combinational read data, zero unless a mapped read is active
//   timer_irq_o    - registered (mtime >= mtimecmp)
//   software_irq_o - msip bit 0
module clint
    import clint_pkg::*;
#(
    parameter int unsigned        TICK_DIV  = 1,
    parameter logic [MTIME_W-1:0] MTIME_RST = 64'h0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic            we_i,
    input  logic [31:0]     addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] rdata_o,
    output logic            timer_irq_o,
    output logic            software_irq_o
);

    logic [MTIME_W-1:0] mtime_q, mtime_d;
    logic [MTIME_W-1:0] mtimecmp_q, mtimecmp_d;
    logic               msip_q, msip_d;
    logic               irq_q;
    logic               tick;
    logic               wr_en;
    reg_sel_e           sel;
    logic               unused_addr_hi;

    assign unused_addr_hi = ^addr_i[31:16];

    clint_tick_div #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_div (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .tick_o(tick)
    );

    assign sel   = decode_off(addr_i[15:0]);
    assign wr_en = req_i && we_i;

    always_comb begin
        rdata_o = '0;
        if (req_i && !we_i) begin
            case (sel)
                REG_MSIP:     rdata_o = {{(XLEN-1){1'b0}}, msip_q};
                REG_CMP_LO:   rdata_o = mtimecmp_q[31:0];
                REG_CMP_HI:   rdata_o = mtimecmp_q[63:32];
                REG_MTIME_LO: rdata_o = mtime_q[31:0];
                REG_MTIME_HI: rdata_o = mtime_q[63:32];
                default:      rdata_o = '0;
            endcase
        end
    end

    // A write to either mtime half replaces the increment entirely, so the
    // untouched half keeps its old value and no carry crosses that cycle.
    always_comb begin
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        mtime_d    = tick ? (mtime_q + 64'd1) : mtime_q;
        if (wr_en) begin
            case (sel)
                REG_MSIP:     msip_d     = wdata_i[0];
                REG_CMP_LO:   mtimecmp_d = {mtimecmp_q[63:32], wdata_i};
                REG_CMP_HI:   mtimecmp_d = {wdata_i, mtimecmp_q[31:0]};
                REG_MTIME_LO: mtime_d    = {mtime_q[63:32], wdata_i};
                REG_MTIME_HI: mtime_d    = {wdata_i, mtime_q[31:0]};
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mtime_q    <= MTIME_RST;
            mtimecmp_q <= MTIMECMP_RST;
            msip_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            irq_q      <= (mtime_q >= mtimecmp_q);
        end
    end

    assign timer_irq_o    = irq_q;
    assign software_irq_o = msip_q;

endmodule

// File: tb/tb_clint.sv
module tb_clint;

    logic        clk_i;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata1, rdata4;
    logic        tirq1, tirq4, sirq1, sirq4;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sbq[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    clint #(.TICK_DIV(1), .MTIME_RST(64'h0)) dut1 (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .we_i          (we_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .rdata_o       (rdata1),
        .timer_irq_o   (tirq1),
        .software_irq_o(sirq1)
    );

    clint #(.TICK_DIV(4), .MTIME_RST(64'h0)) dut4 (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .we_i          (we_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .rdata_o       (rdata4),
        .timer_irq_o   (tirq4),
        .software_irq_o(sirq4)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic push(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sbq.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        sb_t e;
        if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty: observed %h required an entry", obs);
        end else begin
            e = sbq.pop_front();
            n_tests++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Drive one cycle's bus values just after the falling edge.
    task automatic drive(input logic rq, input logic we, input logic [31:0] a,
                         input logic [31:0] d);
        @(negedge clk_i);
        req_i   = rq;
        we_i    = we;
        addr_i  = a;
        wdata_i = d;
    endtask

    task automatic rd(input bit use4, input logic [31:0] a, input logic [31:0] exp,
                      input string tag);
        drive(1'b1, 1'b0, a, 32'h0);
        push(tag, exp);
        #2;
        pop_chk(use4 ? rdata4 : rdata1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, 1'b1, a, d);
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #2;
    endtask

    task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        push(tag, exp);
        pop_chk(obs);
    endtask

    initial begin
        rst_i   = 1'b0;
        req_i   = 1'b0;
        we_i    = 1'b0;
        addr_i  = '0;
        wdata_i = '0;

        // Reset cycles; the msip write issued during reset must be discarded.
        idle();
        wr(32'h0000_0000, 32'h1);
        idle();

        // Reset release with TICK_DIV=4: mtime reads 0,0,0,0 then 1.
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        ck("rst_sirq", {31'b0, sirq1}, 32'h0);
        ck("rst_tirq", {31'b0, tirq1}, 32'h0);
        for (int unsigned i = 0; i < 5; i++) begin
            if (i != 0) drive(1'b1, 1'b0, 32'h0000_BFF8, 32'h0);
            else begin
                req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_BFF8;
            end
            push("div4_mtime", (i == 4) ? 32'd1 : 32'd0);
            #1;
            pop_chk(rdata4);
            ck("div4_tirq", {31'b0, tirq4}, 32'h0);
        end
        rd(1'b0, 32'h0000_4004, 32'hFFFF_FFFF, "rst_cmp_hi");
        rd(1'b0, 32'h0000_4000, 32'hFFFF_FFFF, "rst_cmp_lo");
        rd(1'b0, 32'h0000_0000, 32'h0, "rst_msip");

        // msip set/clear.
        wr(32'h0000_0000, 32'hFFFF_FFFF);
        rd(1'b0, 32'h0000_0000, 32'h1, "msip_rd1");
        ck("sirq_set", {31'b0, sirq1}, 32'h1);
        wr(32'h0000_0000, 32'h0);
        rd(1'b0, 32'h0000_0000, 32'h0, "msip_rd0");
        ck("sirq_clr", {31'b0, sirq1}, 32'h0);

        // Timer compare: mtimecmp = 5, mtime restarted from 0.
        wr(32'h0000_BFF8, 32'h0);
        wr(32'h0000_4000, 32'd5);
        wr(32'h0000_4004, 32'h0);
        for (int unsigned i = 0; i < 4; i++) begin
            rd(1'b0, 32'h0000_BFF8, 32'(2 + i), "cmp_mtime");
            ck("tirq_low", {31'b0, tirq1}, 32'h0);
        end
        rd(1'b0, 32'h0000_BFF8, 32'd6, "cmp_mtime6");
        ck("tirq_rise", {31'b0, tirq1}, 32'h1);
        rd(1'b0, 32'h0000_BFF8, 32'd7, "cmp_mtime7");
        ck("tirq_hold", {31'b0, tirq1}, 32'h1);
        wr(32'h0000_4004, 32'h1);
        ck("tirq_wr_cyc", {31'b0, tirq1}, 32'h1);
        idle();
        ck("tirq_after_wr", {31'b0, tirq1}, 32'h1);
        idle();
        ck("tirq_fall", {31'b0, tirq1}, 32'h0);

        // Carry from lo into hi.
        wr(32'h0000_BFFC, 32'h0);
        wr(32'h0000_BFF8, 32'hFFFF_FFFF);
        rd(1'b0, 32'h0000_BFF8, 32'hFFFF_FFFF, "carry_lo_pre");
        rd(1'b0, 32'h0000_BFFC, 32'h1, "carry_hi");
        rd(1'b0, 32'h0000_BFF8, 32'h1, "carry_lo_post");

        // Write in a tick cycle wins over the increment.
        wr(32'h0000_BFF8, 32'd100);
        rd(1'b0, 32'h0000_BFF8, 32'd100, "tickwr_lo");
        rd(1'b0, 32'h0000_BFFC, 32'h1, "tickwr_hi");
        wr(32'h0000_BFFC, 32'd7);
        rd(1'b0, 32'h0000_BFF8, 32'd102, "hiwr_lo_hold");
        rd(1'b0, 32'h0000_BFFC, 32'd7, "hiwr_hi");

        // Full 64-bit wrap.
        wr(32'h0000_BFFC, 32'hFFFF_FFFF);
        wr(32'h0000_BFF8, 32'hFFFF_FFFF);
        rd(1'b0, 32'h0000_BFFC, 32'hFFFF_FFFF, "wrap_hi_pre");
        rd(1'b0, 32'h0000_BFFC, 32'h0, "wrap_hi_post");
        rd(1'b0, 32'h0000_BFF8, 32'h1, "wrap_lo_post");

        // Unmapped and inactive accesses.
        rd(1'b0, 32'h0000_0008, 32'h0, "unmapped_rd");
        drive(1'b0, 1'b0, 32'h0000_4000, 32'h0);
        push("noreq_rd", 32'h0);
        #2;
        pop_chk(rdata1);
        drive(1'b1, 1'b1, 32'h0000_0008, 32'hFFFF_FFFF);
        push("wr_rdata", 32'h0);
        #2;
        pop_chk(rdata1);
        rd(1'b0, 32'h0000_0000, 32'h0, "unm_msip");
        rd(1'b0, 32'h0000_4000, 32'd5, "unm_cmp_lo");
        rd(1'b0, 32'h1234_4004, 32'h1, "unm_cmp_hi_aliased");
        rd(1'b0, 32'h0000_BFFC, 32'h0, "unm_mtime_hi");
        ck("unm_sirq", {31'b0, sirq1}, 32'h0);

        idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish required finish");
        $fatal(1, "timeout");
    end

endmodule
